// File: rtl/dino_pkg.sv
// rtl/dino_pkg.sv - shared widths, screen size, arbiter state and requester indices
package dino_pkg;
    localparam int X_W          = 8;
    localparam int Y_W          = 7;
    localparam int COL_W        = 3;
    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    localparam int REQ_GROUND = 0;
    localparam int REQ_DINO   = 1;
    localparam int REQ_TREE   = 2;
    localparam int REQ_ERASE  = 3;
endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin selector, first request at or after ptr
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);
    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(ptr_i) + k) % N);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end
endmodule

// File: rtl/plot_arbiter.sv
// rtl/plot_arbiter.sv - pass-locked round-robin arbiter for the VGA pixel-write port
module plot_arbiter
    import dino_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     pause,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       last,
    input  logic [NUM_REQ*X_W-1:0]   x_in,
    input  logic [NUM_REQ*Y_W-1:0]   y_in,
    input  logic [NUM_REQ*COL_W-1:0] colour_in,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [X_W-1:0]           x,
    output logic [Y_W-1:0]           y,
    output logic [COL_W-1:0]         colour,
    output logic                     plot,
    output logic                     busy,
    output logic [1:0]               owner,
    output logic [15:0]              clip_count
);
    localparam int IW = 2;

    arb_state_t         state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic               plot_q, plot_d;
    logic [15:0]        clip_q, clip_d;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IW-1:0]      pick_idx;
    logic [IW-1:0]      sel_idx;
    logic [IW-1:0]      nxt_ptr;
    logic [X_W-1:0]     sel_x;
    logic [Y_W-1:0]     sel_y;
    logic [COL_W-1:0]   sel_col;
    logic               sel_last;
    logic               accept;
    logic               clip;

    rr_picker #(.N(NUM_REQ), .IW(IW)) u_picker (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx)
    );

    // Only IDLE arbitrates; an owned pass is served exclusively until its last pixel.
    always_comb begin
        gnt     = '0;
        sel_idx = owner_q;
        if (!reset && !pause) begin
            if (state_q == IDLE) begin
                gnt     = pick_gnt;
                sel_idx = pick_idx;
            end else begin
                gnt[owner_q] = req[owner_q];
            end
        end
    end

    assign accept = |(gnt & req);

    always_comb begin
        sel_x   = '0;
        sel_y   = '0;
        sel_col = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_idx == IW'(i)) begin
                sel_x   = x_in[i*X_W +: X_W];
                sel_y   = y_in[i*Y_W +: Y_W];
                sel_col = colour_in[i*COL_W +: COL_W];
            end
        end
    end

    assign sel_last = last[sel_idx];
    assign clip     = (int'(sel_x) >= SCREEN_W) || (int'(sel_y) >= SCREEN_H);
    assign nxt_ptr  = (sel_idx == IW'(NUM_REQ-1)) ? '0 : sel_idx + 1'b1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        x_d     = x_q;
        y_d     = y_q;
        col_d   = col_q;
        plot_d  = 1'b0;
        clip_d  = clip_q;
        if (accept) begin
            owner_d = sel_idx;
            x_d     = sel_x;
            y_d     = sel_y;
            col_d   = sel_col;
            plot_d  = !clip;
            if (clip && clip_q != 16'hFFFF) clip_d = clip_q + 16'd1;
            if (sel_last) begin
                state_d = IDLE;
                ptr_d   = nxt_ptr;
            end else begin
                state_d = OWNED;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            col_q   <= '0;
            plot_q  <= 1'b0;
            clip_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            x_q     <= x_d;
            y_q     <= y_d;
            col_q   <= col_d;
            plot_q  <= plot_d;
            clip_q  <= clip_d;
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign colour     = col_q;
    assign plot       = plot_q;
    assign busy       = (state_q == OWNED);
    assign owner      = owner_q;
    assign clip_count = clip_q;
endmodule

// File: tb/tb_plot_arbiter.sv
// tb/tb_plot_arbiter.sv - per-cycle vector table with a pixel scoreboard for plot_arbiter
module tb_plot_arbiter;
    logic        clock = 1'b0;
    logic        reset, pause;
    logic [3:0]  req, last, gnt;
    logic [31:0] x_in;
    logic [27:0] y_in;
    logic [11:0] colour_in;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot, busy;
    logic [1:0]  owner;
    logic [15:0] clip_count;

    always #5 clock = ~clock;

    plot_arbiter dut (
        .clock(clock), .reset(reset), .pause(pause), .req(req), .last(last),
        .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .gnt(gnt),
        .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy),
        .owner(owner), .clip_count(clip_count)
    );

    typedef struct packed {
        logic       rst;
        logic       pause;
        logic [3:0] req;
        logic [3:0] last;
        logic [3:0] gnt;
        logic       busy;
        logic [1:0] owner;
        logic       ovr;
        logic [7:0] xo;
        logic [6:0] yo;
    } vec_t;

    typedef struct packed {
        logic        plot;
        logic        chk;
        logic [7:0]  x;
        logic [6:0]  y;
        logic [2:0]  c;
        logic [15:0] clip;
        logic        busy;
        logic [1:0]  owner;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[22];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   mclip  = 0;

    task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h want %0h", name, id, act, want);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic pa, input logic [3:0] rq,
                                input logic [3:0] ls, input logic [3:0] gn, input logic bz,
                                input logic [1:0] ow, input logic ovr = 1'b0,
                                input logic [7:0] xo = 8'd0, input logic [6:0] yo = 7'd0);
        vec_t v;
        v.rst = rst; v.pause = pa; v.req = rq; v.last = ls; v.gnt = gn;
        v.busy = bz; v.owner = ow; v.ovr = ovr; v.xo = xo; v.yo = yo;
        return v;
    endfunction

    // Drive one cycle, check the grant, queue the expected registered result, then compare it.
    task automatic run(input vec_t v);
        exp_t        e;
        int          w;
        logic [7:0]  px;
        logic [6:0]  py;
        logic [2:0]  pc;
        reset = v.rst;
        pause = v.pause;
        req   = v.req;
        last  = v.last;
        for (int i = 0; i < 4; i++) begin
            x_in[i*8 +: 8]      = v.ovr ? v.xo : 8'(cyc * 4 + i);
            y_in[i*7 +: 7]      = v.ovr ? v.yo : 7'(i * 20 + cyc % 20);
            colour_in[i*3 +: 3] = 3'(cyc + i);
        end
        #1;
        check("gnt", cyc, 32'(gnt), 32'(v.gnt));
        e = '0;
        e.busy  = v.busy;
        e.owner = v.owner;
        w = -1;
        for (int i = 0; i < 4; i++) if (v.gnt[i] && v.req[i]) w = i;
        if (v.rst) begin
            mclip = 0;
            e.chk = 1'b1;
        end else if (w >= 0) begin
            px = x_in[w*8 +: 8];
            py = y_in[w*7 +: 7];
            pc = colour_in[w*3 +: 3];
            if (int'(px) >= 160 || int'(py) >= 120) begin
                if (mclip < 65535) mclip++;
            end else begin
                e.plot = 1'b1;
                e.chk  = 1'b1;
                e.x    = px;
                e.y    = py;
                e.c    = pc;
            end
        end
        e.clip = 16'(mclip);
        sb.push_back(e);
        @(posedge clock);
        @(negedge clock);
        e = sb.pop_front();
        check("plot", cyc, 32'(plot), 32'(e.plot));
        if (e.chk) begin
            check("x", cyc, 32'(x), 32'(e.x));
            check("y", cyc, 32'(y), 32'(e.y));
            check("colour", cyc, 32'(colour), 32'(e.c));
        end
        check("busy", cyc, 32'(busy), 32'(e.busy));
        check("owner", cyc, 32'(owner), 32'(e.owner));
        check("clip_count", cyc, 32'(clip_count), 32'(e.clip));
        cyc++;
    endtask

    initial begin
        reset = 1'b1; pause = 1'b0; req = '0; last = '0;
        x_in = '0; y_in = '0; colour_in = '0;
        //             rst pa  req     last    gnt     bsy owner
        tbl[0]  = mk(1, 0, 4'b1111, 4'b0000, 4'b0000, 0, 2'd0);
        tbl[1]  = mk(1, 0, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0);
        tbl[2]  = mk(0, 0, 4'b0010, 4'b0000, 4'b0010, 1, 2'd1);
        tbl[3]  = mk(0, 0, 4'b0010, 4'b0000, 4'b0010, 1, 2'd1);
        tbl[4]  = mk(0, 0, 4'b0010, 4'b0000, 4'b0010, 1, 2'd1);
        tbl[5]  = mk(0, 0, 4'b0010, 4'b0010, 4'b0010, 0, 2'd1);
        tbl[6]  = mk(0, 0, 4'b1011, 4'b1011, 4'b1000, 0, 2'd3);
        tbl[7]  = mk(0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 2'd3);
        tbl[8]  = mk(0, 0, 4'b0101, 4'b0000, 4'b0001, 1, 2'd0);
        tbl[9]  = mk(0, 0, 4'b0101, 4'b0001, 4'b0001, 0, 2'd0);
        tbl[10] = mk(0, 0, 4'b0100, 4'b0000, 4'b0100, 1, 2'd2);
        tbl[11] = mk(0, 0, 4'b0100, 4'b0100, 4'b0100, 0, 2'd2);
        tbl[12] = mk(0, 0, 4'b1000, 4'b0000, 4'b1000, 1, 2'd3);
        tbl[13] = mk(0, 0, 4'b1001, 4'b0000, 4'b1000, 1, 2'd3);
        tbl[14] = mk(0, 0, 4'b1001, 4'b1000, 4'b1000, 0, 2'd3);
        tbl[15] = mk(0, 0, 4'b0001, 4'b0001, 4'b0001, 0, 2'd0);
        tbl[16] = mk(0, 0, 4'b0010, 4'b0000, 4'b0010, 1, 2'd1, 1, 8'd159, 7'd119);
        tbl[17] = mk(0, 0, 4'b0010, 4'b0010, 4'b0010, 0, 2'd1, 1, 8'd160, 7'd50);
        tbl[18] = mk(0, 0, 4'b0100, 4'b0100, 4'b0100, 0, 2'd2, 1, 8'd10, 7'd120);
        tbl[19] = mk(0, 0, 4'b1000, 4'b0000, 4'b1000, 1, 2'd3);
        tbl[20] = mk(0, 0, 4'b0111, 4'b0000, 4'b0000, 1, 2'd3);
        tbl[21] = mk(0, 0, 4'b1000, 4'b1000, 4'b1000, 0, 2'd3);

        @(negedge clock);
        for (int i = 0; i < 22; i++) run(tbl[i]);

        // pause inside an owned pass, then while idle
        run(mk(0, 0, 4'b0001, 4'b0000, 4'b0001, 1, 2'd0));
        for (int i = 0; i < 3; i++) run(mk(0, 1, 4'b1111, 4'b0000, 4'b0000, 1, 2'd0));
        run(mk(0, 0, 4'b0001, 4'b0001, 4'b0001, 0, 2'd0));
        run(mk(0, 1, 4'b1111, 4'b1111, 4'b0000, 0, 2'd0));

        // reset mid-pass drops ownership and rewinds the pointer to requester 0
        run(mk(0, 0, 4'b0100, 4'b0000, 4'b0100, 1, 2'd2));
        run(mk(1, 0, 4'b0100, 4'b0000, 4'b0000, 0, 2'd0));
        run(mk(0, 0, 4'b1111, 4'b0000, 4'b0001, 1, 2'd0));
        run(mk(0, 0, 4'b0001, 4'b0001, 4'b0001, 0, 2'd0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
